// File: rtl/apb_rr_master.sv
// apb_rr_master: round-robin APB master sharing one APB slave between NUM_REQ requesters.
// Arbitrates among pending requests, runs the APB SETUP/ACCESS sequence and returns read
// data, or a timeout error when the slave holds pready low for TIMEOUT_CYC ACCESS cycles.
//
// Ports
//   pclk_i, prst_n         clock (rising edge), synchronous active-low reset
//   req_valid_i            per-requester request, held until its rsp_valid_o pulse
//   req_write_i            per-requester direction (1 = write)
//   req_addr_i/wdata_i     packed per-requester address / write data
//   rsp_valid_o            one-hot completion pulse (combinational)
//   rsp_err_o              timeout abort flag, qualifies rsp_valid_o
//   rsp_rdata_o            read data on successful reads, else 0
//   busy_o                 high in SETUP or ACCESS
//   grant_id_o             current or last grantee
//   psel_o..pwdata_o       registered APB controls toward the slave
//   prdata_i, pready_i     APB response from the slave
module apb_rr_master #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic                       pclk_i,
  input  logic                       prst_n,
  input  logic [NUM_REQ-1:0]         req_valid_i,
  input  logic [NUM_REQ-1:0]         req_write_i,
  input  logic [NUM_REQ*ADDR_W-1:0]  req_addr_i,
  input  logic [NUM_REQ*DATA_W-1:0]  req_wdata_i,
  output logic [NUM_REQ-1:0]         rsp_valid_o,
  output logic                       rsp_err_o,
  output logic [DATA_W-1:0]          rsp_rdata_o,
  output logic                       busy_o,
  output logic [$clog2(NUM_REQ)-1:0] grant_id_o,
  output logic                       psel_o,
  output logic                       penable_o,
  output logic                       pwrite_o,
  output logic [ADDR_W-1:0]          paddr_o,
  output logic [DATA_W-1:0]          pwdata_o,
  input  logic [DATA_W-1:0]          prdata_i,
  input  logic                       pready_i
);

  localparam int unsigned IdW  = $clog2(NUM_REQ);
  localparam int unsigned CntW = $clog2(TIMEOUT_CYC);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

  state_e             state_q, state_d;
  logic               psel_q, psel_d;
  logic               penable_q, penable_d;
  logic               pwrite_q, pwrite_d;
  logic [ADDR_W-1:0]  paddr_q, paddr_d;
  logic [DATA_W-1:0]  pwdata_q, pwdata_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [IdW-1:0]     last_q, last_d;
  logic [IdW-1:0]     grant_id_q, grant_id_d;

  logic [IdW-1:0]     pick;
  logic [IdW:0]       idx;
  logic               sel_write;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_wdata;
  logic               done;

  // Round-robin pick: scanning from the far end downwards lets the nearest valid index after
  // last_q win without an early exit from the loop.
  always_comb begin
    pick = last_q;
    idx  = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      idx = {1'b0, last_q} + (IdW+1)'(i);
      if (idx >= (IdW+1)'(NUM_REQ)) idx = idx - (IdW+1)'(NUM_REQ);
      if (req_valid_i[idx[IdW-1:0]]) pick = idx[IdW-1:0];
    end
  end

  always_comb begin
    sel_write = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (pick == IdW'(k)) begin
        sel_write = req_write_i[k];
        sel_addr  = req_addr_i[k*ADDR_W +: ADDR_W];
        sel_wdata = req_wdata_i[k*DATA_W +: DATA_W];
      end
    end
  end

  // pready wins over a coinciding timeout; rsp_err_o below is derived from pready alone.
  assign done = (state_q == StAccess) && (pready_i || (cnt_q == CntW'(TIMEOUT_CYC - 1)));

  // State register
  always_ff @(posedge pclk_i) begin
    if (!prst_n) begin
      state_q    <= StIdle;
      psel_q     <= 1'b0;
      penable_q  <= 1'b0;
      pwrite_q   <= 1'b0;
      paddr_q    <= '0;
      pwdata_q   <= '0;
      cnt_q      <= '0;
      last_q     <= IdW'(NUM_REQ - 1);
      grant_id_q <= '0;
    end else begin
      state_q    <= state_d;
      psel_q     <= psel_d;
      penable_q  <= penable_d;
      pwrite_q   <= pwrite_d;
      paddr_q    <= paddr_d;
      pwdata_q   <= pwdata_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      grant_id_q <= grant_id_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    psel_d     = psel_q;
    penable_d  = penable_q;
    pwrite_d   = pwrite_q;
    paddr_d    = paddr_q;
    pwdata_d   = pwdata_q;
    cnt_d      = cnt_q;
    last_d     = last_q;
    grant_id_d = grant_id_q;
    unique case (state_q)
      StIdle: begin
        if (|req_valid_i) begin
          last_d     = pick;
          grant_id_d = pick;
          pwrite_d   = sel_write;
          paddr_d    = sel_addr;
          pwdata_d   = sel_wdata;
          psel_d     = 1'b1;
          penable_d  = 1'b0;
          state_d    = StSetup;
        end
      end
      StSetup: begin
        penable_d = 1'b1;
        cnt_d     = '0;
        state_d   = StAccess;
      end
      StAccess: begin
        if (done) begin
          psel_d    = 1'b0;
          penable_d = 1'b0;
          state_d   = StIdle;
        end else begin
          // Never passes TIMEOUT_CYC-1: done fires there first.
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    rsp_valid_o = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      rsp_valid_o[k] = done && (grant_id_q == IdW'(k));
    end
    rsp_err_o   = done && !pready_i;
    rsp_rdata_o = (done && pready_i && !pwrite_q) ? prdata_i : '0;
    busy_o      = (state_q != StIdle);
  end

  assign psel_o     = psel_q;
  assign penable_o  = penable_q;
  assign pwrite_o   = pwrite_q;
  assign paddr_o    = paddr_q;
  assign pwdata_o   = pwdata_q;
  assign grant_id_o = grant_id_q;

endmodule

// File: tb/tb_apb_rr_master.sv
// Bench for apb_rr_master: vector table, hand sequences for reset/late arrival, random traffic.
// Includes a wait-state slave with memory, and a transaction-level reference for arbitration,
// latency and memory contents.
module tb_apb_rr_master;
  localparam int N  = 4;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int TO = 16;

  logic pclk   = 1'b0;
  logic prst_n = 1'b0;
  logic [N-1:0]    req_valid, req_write, rsp_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic            rsp_err, busy, psel, penable, pwrite, pready;
  logic [DW-1:0]   rsp_rdata, pwdata, prdata;
  logic [AW-1:0]   paddr;
  logic [1:0]      grant_id;

  always #5 pclk = ~pclk;

  apb_rr_master #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
    .pclk_i     (pclk),
    .prst_n     (prst_n),
    .req_valid_i(req_valid),
    .req_write_i(req_write),
    .req_addr_i (req_addr),
    .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid),
    .rsp_err_o  (rsp_err),
    .rsp_rdata_o(rsp_rdata),
    .busy_o     (busy),
    .grant_id_o (grant_id),
    .psel_o     (psel),
    .penable_o  (penable),
    .pwrite_o   (pwrite),
    .paddr_o    (paddr),
    .pwdata_o   (pwdata),
    .prdata_i   (prdata),
    .pready_i   (pready)
  );

  // Requesters
  logic [N-1:0]  pend;
  logic          r_wr   [N];
  logic [AW-1:0] r_addr [N];
  logic [DW-1:0] r_wd   [N];

  assign req_valid = pend;
  always_comb begin
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    for (int i = 0; i < N; i++) begin
      req_write[i]            = r_wr[i];
      req_addr[i*AW +: AW]    = r_addr[i];
      req_wdata[i*DW +: DW]   = r_wd[i];
    end
  end

  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    return (a == 8'h10) ? 32'hDEAD_BEEF : {24'hC0DE00, a};
  endfunction

  // Slave: pready after wait_n ACCESS wait cycles, memory written on completion.
  logic [DW-1:0] slv_mem [256];
  int            acc_cnt;
  int            wait_n;
  bit            mem_ready = 1'b0;

  assign pready = psel && penable && (acc_cnt == wait_n);

  always @(posedge pclk) begin
    if (!mem_ready) begin
      for (int a = 0; a < 256; a++) slv_mem[a] <= init_val(8'(a));
      mem_ready <= 1'b1;
    end else if (prst_n && psel && penable && pready && pwrite) begin
      slv_mem[paddr] <= pwdata;
    end
    prdata <= slv_mem[paddr];
    if (!prst_n || !(psel && penable) || pready) acc_cnt <= 0;
    else acc_cnt <= acc_cnt + 1;
  end

  // Reference state
  logic [DW-1:0] ref_mem [256];
  int            last_m;
  int            total = 0;
  int            bad   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] m, input int last);
    for (int k = 1; k <= N; k++) if (m[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  task automatic set_fields(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
    for (int i = 0; i < N; i++) begin
      r_wr[i]   = wr;
      r_addr[i] = addr + 8'(i);
      r_wd[i]   = wd + 32'(i);
    end
  endtask

  // Serve all requesters in mask (plus late ones injected after step late_at) and check every
  // phase against the reference. Called and returns just after a negedge with the DUT idle.
  task automatic serve(input logic [N-1:0] mask, input int w, input logic [N-1:0] late,
                       input int late_at, output int first_g, output logic [DW-1:0] first_rd,
                       output logic first_err);
    int            steps = 0;
    int            guard = 0;
    int            n = 0;
    int            g = 0;
    int            served = 0;
    int            exp_n;
    bit            in_xfer = 1'b0;
    bit            after_rsp = 1'b0;
    logic          exp_err;
    logic [DW-1:0] exp_rd;
    pend      = mask;
    wait_n    = w;
    first_g   = -1;
    first_rd  = '0;
    first_err = 1'b0;
    exp_n     = (w >= TO) ? TO : w + 1;
    exp_err   = (w >= TO);
    while ((pend != 0 || in_xfer || steps < late_at) && guard < 400) begin
      @(negedge pclk);
      steps++;
      guard++;
      if (in_xfer) begin
        n++;
        if (n < exp_n) begin
          check("access_wait", {psel, penable, rsp_valid}, {2'b11, 4'b0000});
        end else begin
          exp_rd = (!r_wr[g] && !exp_err) ? ref_mem[r_addr[g]] : '0;
          check("rsp_valid", rsp_valid, 4'b0001 << g);
          check("rsp_err", rsp_err, exp_err);
          check("rsp_rdata", rsp_rdata, exp_rd);
          if (r_wr[g] && !exp_err) ref_mem[r_addr[g]] = r_wd[g];
          if (served == 0) begin
            first_g   = g;
            first_rd  = rsp_rdata;
            first_err = rsp_err;
          end
          served++;
          pend[g]   = 1'b0;
          in_xfer   = 1'b0;
          after_rsp = 1'b1;
        end
      end else if (after_rsp) begin
        check("gap_idle", {psel, busy}, 2'b00);
        after_rsp = 1'b0;
      end else if (pend != 0) begin
        g = rr_pick(pend, last_m);
        check("setup_phase", {psel, penable, busy}, 3'b101);
        check("grant_id", grant_id, g);
        check("paddr", paddr, r_addr[g]);
        check("pwrite", pwrite, r_wr[g]);
        check("pwdata", pwdata, r_wd[g]);
        last_m  = g;
        in_xfer = 1'b1;
        n       = 0;
      end else begin
        check("idle_psel", psel, 0);
      end
      if (steps == late_at) pend = pend | late;
    end
    check("serve_bound", guard < 400, 1);
    @(negedge pclk);
    check("end_idle", {psel, penable, busy}, 0);
  endtask

  typedef struct {
    logic [N-1:0]  mask;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
    int            w;
    int            exp_g;
    logic [DW-1:0] exp_rd;
    logic          exp_err;
  } vec_t;

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=%h exp=%h", 0, 1);
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t          tbl [12];
    int            g;
    logic [DW-1:0] rd;
    logic          er;
    logic [N-1:0]  m, lt;

    // First-grant expectations follow the round-robin history from reset (last_grant = 3).
    tbl[0]  = '{4'b0001, 1'b1, 8'h20, 32'h1111_0000, 0,  0, 32'h0,         1'b0};
    tbl[1]  = '{4'b0001, 1'b0, 8'h20, 32'h0,         2,  0, 32'h1111_0000, 1'b0};
    tbl[2]  = '{4'b1010, 1'b1, 8'h40, 32'h2222_0000, 1,  1, 32'h0,         1'b0};
    tbl[3]  = '{4'b1010, 1'b0, 8'h40, 32'h0,         0,  1, 32'h2222_0001, 1'b0};
    tbl[4]  = '{4'b1111, 1'b0, 8'h40, 32'h0,         3,  0, 32'hC0DE_0040, 1'b0};
    tbl[5]  = '{4'b0100, 1'b1, 8'h3A, 32'hA5A4_FFFF, 1,  2, 32'h0,         1'b0};
    tbl[6]  = '{4'b0100, 1'b0, 8'h3A, 32'h0,         4,  2, 32'hA5A5_0001, 1'b0};
    tbl[7]  = '{4'b0001, 1'b0, 8'h10, 32'h0,         3,  0, 32'hDEAD_BEEF, 1'b0};
    tbl[8]  = '{4'b0010, 1'b0, 8'h50, 32'h0,         20, 1, 32'h0,         1'b1};
    tbl[9]  = '{4'b0010, 1'b0, 8'h50, 32'h0,         15, 1, 32'hC0DE_0051, 1'b0};
    tbl[10] = '{4'b1000, 1'b1, 8'h57, 32'h3333_0000, 16, 3, 32'h0,         1'b1};
    tbl[11] = '{4'b1000, 1'b0, 8'h57, 32'h0,         0,  3, 32'hC0DE_005A, 1'b0};

    pend   = '0;
    wait_n = 0;
    set_fields(1'b0, 8'h00, 32'h0);
    for (int a = 0; a < 256; a++) ref_mem[a] = init_val(8'(a));

    // Reset values
    repeat (3) @(negedge pclk);
    check("rst_apb", {psel, penable, pwrite, busy}, 0);
    check("rst_paddr", paddr, 0);
    check("rst_pwdata", pwdata, 0);
    check("rst_grant", grant_id, 0);
    check("rst_rsp", rsp_valid, 0);
    prst_n = 1'b1;
    last_m = N - 1;

    for (int t = 0; t < 12; t++) begin
      set_fields(tbl[t].wr, tbl[t].addr, tbl[t].wd);
      serve(tbl[t].mask, tbl[t].w, '0, 0, g, rd, er);
      check($sformatf("vec%0d_grant", t), g, tbl[t].exp_g);
      check($sformatf("vec%0d_rdata", t), rd, tbl[t].exp_rd);
      check($sformatf("vec%0d_err", t), er, tbl[t].exp_err);
    end

    // Late arrival: requester 1 shows up during requester 3's ACCESS.
    set_fields(1'b0, 8'h60, 32'h0);
    serve(4'b1000, 5, 4'b0010, 3, g, rd, er);
    check("late_first", g, 3);
    check("late_last_grant", grant_id, 1);

    // Reset in the middle of ACCESS: silent abandon, then requester 0 first.
    set_fields(1'b0, 8'h70, 32'h0);
    pend   = 4'b0100;
    wait_n = 40;
    repeat (4) @(negedge pclk);
    check("pre_rst_access", {psel, penable, busy}, 3'b111);
    prst_n = 1'b0;
    @(negedge pclk);
    check("rst_mid_apb", {psel, penable, busy, rsp_valid}, 0);
    check("rst_mid_grant", grant_id, 0);
    pend = '0;
    @(negedge pclk);
    check("rst_hold_rsp", rsp_valid, 0);
    last_m = N - 1;
    prst_n = 1'b1;
    serve(4'b1101, 2, '0, 0, g, rd, er);
    check("rst_first_grant", g, 0);

    // Random traffic
    for (int it = 0; it < 30; it++) begin
      for (int i = 0; i < N; i++) begin
        r_wr[i]   = 1'($urandom);
        r_addr[i] = 8'($urandom);
        r_wd[i]   = $urandom;
      end
      m  = 4'($urandom_range(1, 15));
      lt = 4'($urandom) & ~m;
      serve(m, $urandom_range(0, 18), lt, $urandom_range(1, 8), g, rd, er);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
